// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI frames into {cmd, payload} words and returns RAM read data on MISO.
// Optional macro SPI_CMD_CHECK_EN adds cmd_err and checks frame bit W-2 against the read state.
module spi_slave_if #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
`ifdef SPI_CMD_CHECK_EN
    ,
    output logic                 cmd_err
`endif
);

    localparam int W   = ADDR_SIZE + 2;
    localparam int CW  = $clog2(W + 1);
    localparam int TCW = (ADDR_SIZE > 2) ? $clog2(ADDR_SIZE) : 1;

    // state     | meaning
    // IDLE      | waiting for SS_n low
    // CHK_CMD   | sampling frame bit W-1 to choose write or read
    // WRITE     | shifting in a write address/data frame
    // READ_ADD  | shifting in a read address frame
    // READ_DATA | shifting in a read data frame, then returning RAM data on MISO
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t               state;
    logic [W-2:0]         rx_sreg;
    logic [CW-1:0]        bit_cnt;
    logic                 frame_done;
    logic                 rd_addr_seen;
    logic [1:0]           tx_phase;
    logic [ADDR_SIZE-1:0] tx_sreg;
    logic [TCW-1:0]       tx_cnt;
    logic                 tx_busy;
    logic [W-1:0]         rx_word;
    logic                 cmd_ok;

    assign rx_word = {rx_sreg, MOSI};

`ifdef SPI_CMD_CHECK_EN
    assign cmd_ok = !(((state == READ_ADD) && rx_word[W-2]) ||
                      ((state == READ_DATA) && !rx_word[W-2]));
`else
    assign cmd_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rx_sreg      <= '0;
            bit_cnt      <= '0;
            frame_done   <= 1'b0;
            rd_addr_seen <= 1'b0;
            tx_phase     <= 2'd0;
            tx_sreg      <= '0;
            tx_cnt       <= '0;
            tx_busy      <= 1'b0;
            MISO         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
`ifdef SPI_CMD_CHECK_EN
            cmd_err      <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef SPI_CMD_CHECK_EN
            cmd_err  <= 1'b0;
`endif
            if (SS_n) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                frame_done <= 1'b0;
                tx_phase   <= 2'd0;
                tx_cnt     <= '0;
                tx_busy    <= 1'b0;
                MISO       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= CHK_CMD;
                        frame_done <= 1'b0;
                    end
                    CHK_CMD: begin
                        rx_sreg <= {{(W-2){1'b0}}, MOSI};
                        bit_cnt <= CW'(W - 1);
                        if (!MOSI)
                            state <= WRITE;
                        else if (rd_addr_seen)
                            state <= READ_DATA;
                        else
                            state <= READ_ADD;
                    end
                    default: begin
                        if (!frame_done) begin
                            rx_sreg <= rx_word[W-2:0];
                            bit_cnt <= bit_cnt - 1'b1;
                            if (bit_cnt == CW'(1)) begin
                                frame_done <= 1'b1;
                                if (cmd_ok) begin
                                    rx_data  <= rx_word;
                                    rx_valid <= 1'b1;
                                    if (state == READ_ADD)
                                        rd_addr_seen <= 1'b1;
                                    if (state == READ_DATA) begin
                                        rd_addr_seen <= 1'b0;
                                        tx_phase     <= 2'd1;
                                    end
                                end else begin
`ifdef SPI_CMD_CHECK_EN
                                    cmd_err <= 1'b1;
`endif
                                end
                            end
                        end else if (tx_phase == 2'd1) begin
                            // one cycle for the RAM to register its read data
                            tx_phase <= 2'd2;
                        end else if (tx_phase == 2'd2) begin
                            tx_phase <= 2'd3;
                            if (tx_valid) begin
                                MISO    <= tx_data[ADDR_SIZE-1];
                                tx_sreg <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                                tx_cnt  <= TCW'(ADDR_SIZE - 1);
                                tx_busy <= 1'b1;
                            end
                        end else if (tx_busy) begin
                            if (tx_cnt != '0) begin
                                MISO    <= tx_sreg[ADDR_SIZE-1];
                                tx_sreg <= {tx_sreg[ADDR_SIZE-2:0], 1'b0};
                                tx_cnt  <= tx_cnt - 1'b1;
                            end else begin
                                MISO    <= 1'b0;
                                tx_busy <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: directed frames, expected rx words queued, monitor pops on rx_valid.
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_CMD_CHECK_EN
    logic       cmd_err;
    int         err_seen = 0;
`endif

    int total = 0;
    int bad   = 0;
    logic [9:0] rxq[$];
    logic [9:0] exp_rx;

    spi_slave_if #(.ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_CMD_CHECK_EN
        ,
        .cmd_err  (cmd_err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            total++;
            if (rxq.size() == 0) begin
                bad++;
                $display("FAIL rx_unexpected actual=%h required=no_pulse", rx_data);
            end else begin
                exp_rx = rxq.pop_front();
                if (rx_data !== exp_rx) begin
                    bad++;
                    $display("FAIL rx_data actual=%h required=%h", rx_data, exp_rx);
                end
            end
        end
`ifdef SPI_CMD_CHECK_EN
        if (cmd_err) err_seen++;
`endif
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Drives SS_n low, one idle edge, then nbits of w MSB first; returns at the negedge after the last bit edge.
    task automatic send(input logic [9:0] w, input int nbits, input bit expect_rx);
        logic [9:0] v;
        v = w;
        if (expect_rx) rxq.push_back(w);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            MOSI = v[9-i];
        end
        @(negedge clk);
        MOSI = 1'b1;
    endtask

    task automatic end_frame();
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Full read-data frame with RAM model returning d; checks the first nbits MISO bits.
    task automatic read_back(input logic [9:0] w, input logic [7:0] d, input bit vld, input int nbits);
        logic [7:0] dv;
        dv = d;
        send(w, 10, 1'b1);
        @(negedge clk);
        tx_valid = vld;
        tx_data  = d;
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            chk($sformatf("miso_bit%0d", k), {15'd0, MISO}, {15'd0, vld ? dv[7-k] : 1'b0});
        end
    endtask

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rx_data", {6'd0, rx_data}, 16'h0000);
        chk("reset_rx_valid", {15'd0, rx_valid}, 16'h0000);
        chk("reset_miso", {15'd0, MISO}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // write address
        send(10'h016, 10, 1'b1);
        chk("wr_addr_miso", {15'd0, MISO}, 16'h0000);
        repeat (3) @(negedge clk);
        chk("wr_addr_hold", {6'd0, rx_data}, 16'h0016);
        end_frame();

        // write data then read address
        send(10'h1A5, 10, 1'b1);
        end_frame();
        send(10'h216, 10, 1'b1);
        end_frame();
        chk("rd_addr_seen_set", {15'd0, dut.rd_addr_seen}, 16'h0001);

        // reset mid-frame after 4 bits
        send(10'h3FF, 4, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midreset_rx_data", {6'd0, rx_data}, 16'h0000);
        chk("midreset_miso", {15'd0, MISO}, 16'h0000);
        chk("midreset_seen", {15'd0, dut.rd_addr_seen}, 16'h0000);
        @(negedge clk);
        SS_n = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        // read address, then read data returning A5
        send(10'h216, 10, 1'b1);
        end_frame();
        read_back(10'h300, 8'hA5, 1'b1, 8);
        @(negedge clk);
        chk("rd_after_miso", {15'd0, MISO}, 16'h0000);
        tx_valid = 1'b0;
        @(negedge clk);
        chk("rd_after_miso2", {15'd0, MISO}, 16'h0000);
        end_frame();
        chk("rd_data_seen_clr", {15'd0, dut.rd_addr_seen}, 16'h0000);

        // aborted write after 5 bits, then full frame
        send(10'h0AA, 5, 1'b0);
        end_frame();
        send(10'h0FF, 10, 1'b1);
        end_frame();
        chk("after_abort_rx", {6'd0, rx_data}, 16'h00FF);

        // read data aborted mid shift-out after 3 bits
        send(10'h203, 10, 1'b1);
        end_frame();
        read_back(10'h303, 8'h3C, 1'b1, 3);
        SS_n = 1'b1;
        @(negedge clk);
        chk("abort_tx_miso", {15'd0, MISO}, 16'h0000);
        tx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // read data with tx_valid low: MISO stays 0
        send(10'h2AA, 10, 1'b1);
        end_frame();
        read_back(10'h3FF, 8'hFF, 1'b0, 9);
        end_frame();

`ifdef SPI_CMD_CHECK_EN
        begin
            int before;
            before = err_seen;
            send(10'h301, 10, 1'b0);
            end_frame();
            chk("cmd_err_pulse", 16'(err_seen - before), 16'h0001);
            chk("cmd_err_seen", {15'd0, dut.rd_addr_seen}, 16'h0000);
        end
`endif

        repeat (2) @(negedge clk);
        chk("rx_queue_empty", 16'(rxq.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
